ntt_loader: RTL and testbench

Streams polynomial coefficients in one per cycle and reduces each one modulo Q. It packs a full frame of D coefficients into the flat D*N-bit vector that the combinational `ntt` stage takes on its `a` input. Two ping-pong banks let the next frame fill while the current one is presented. The block sits directly upstream of `ntt`: its `a` output wires straight to `ntt.a`, and `a_valid`/`a_ready` frame when that vector is stable.

---
 rtl/ntt_pkg.sv | 16 +
 rtl/ntt_coef_reduce.sv | 16 +
 rtl/ntt_loader.sv | 88 ++++++++
 tb/tb_ntt_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants for the NTT front end: default ring parameters and bank selects.
package ntt_pkg;

  localparam int N_DEF = 9;
  localparam int D_DEF = 8;
  localparam int Q_DEF = 257;
  localparam int IDXW  = $clog2(D_DEF);

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  function automatic logic other_bank(input logic b);
    return (b == BANK0) ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/ntt_coef_reduce.sv
// Single conditional subtraction by Q; exact for any N-bit input because 2^N <= 2Q.
module ntt_coef_reduce
  import ntt_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic [N-1:0] coef,
  output logic [N-1:0] r
);

  localparam logic [N-1:0] QN = N'(Q);

  assign r = (coef >= QN) ? coef - QN : coef;

endmodule

// File: rtl/ntt_loader.sv
// Streams coefficients into two ping-pong banks and presents each completed frame
// as the flat vector feeding the ntt stage.
//
// bank state | meaning
// EMPTY      | full=0, not the write bank or idx=0
// FILLING    | full=0, write bank with idx>0
// FULL       | full=1, frame complete, contents frozen until released
module ntt_loader
  import ntt_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int D = D_DEF,
  parameter int Q = Q_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_coef,
  input  logic           in_last,
  output logic [D*N-1:0] a,
  output logic           a_valid,
  input  logic           a_ready,
  output logic           frame_err
);

  localparam int IW = $clog2(D);
  localparam logic [IW-1:0] IDX_LAST = IW'(D - 1);

  logic [N-1:0]  mem [2][D];
  logic [1:0]    full;
  logic [IW-1:0] idx;
  logic          wr_bank;
  logic          rd_bank;
  logic [N-1:0]  coef_r;
  logic          acc;
  logic          rel;
  logic          at_last;
  logic          complete;
  logic          violation;

  ntt_coef_reduce #(.N(N), .Q(Q)) u_reduce (
    .coef (in_coef),
    .r    (coef_r)
  );

  assign in_ready  = !full[wr_bank];
  assign a_valid   = full[rd_bank];
  assign acc       = in_valid && in_ready;
  assign rel       = a_valid && a_ready;
  assign at_last   = (idx == IDX_LAST);
  assign complete  = acc && at_last && in_last;
  assign violation = acc && (at_last != in_last);

  always_comb begin
    a = '0;
    for (int k = 0; k < D; k++) a[N*k +: N] = mem[rd_bank][k];
  end

  // Completion targets wr_bank (not full) and release targets rd_bank (full),
  // so when both fire in one cycle they always touch different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < D; k++) mem[b][k] <= '0;
      full      <= '0;
      idx       <= '0;
      wr_bank   <= BANK0;
      rd_bank   <= BANK0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= violation;
      if (acc) begin
        mem[wr_bank][idx] <= coef_r;
        idx <= (at_last || in_last) ? '0 : idx + 1'b1;
      end
      if (complete) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= other_bank(wr_bank);
      end
      if (rel) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= other_bank(rd_bank);
      end
    end
  end

endmodule

// File: tb/tb_ntt_loader.sv
// Self-checking bench for ntt_loader against a frame-level queue model.
module tb_ntt_loader;
  import ntt_pkg::*;

  localparam int N = 9;
  localparam int D = 8;
  localparam int Q = 257;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           a_ready = 1'b0;
  logic [N-1:0]   in_coef = '0;
  logic           in_ready;
  logic           a_valid;
  logic           frame_err;
  logic [D*N-1:0] a;

  int n_checks = 0;
  int n_pass = 0;

  logic [N-1:0]   cur[$];
  logic [D*N-1:0] pend[$];
  logic           exp_err = 1'b0;
  logic [N-1:0]   gen[24];

  ntt_loader #(.N(N), .D(D), .Q(Q)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .in_last   (in_last),
    .a         (a),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_reduce(input int unsigned c);
    return N'(c % Q);
  endfunction

  function automatic logic [D*N-1:0] frame_of(input int base);
    logic [D*N-1:0] f;
    f = '0;
    for (int k = 0; k < D; k++) f[N*k +: N] = ref_reduce(gen[base+k]);
    return f;
  endfunction

  // One clock: drive inputs, advance the model at the edge, return #1 after it.
  task automatic step(input logic v, input logic [N-1:0] c, input logic l,
                      input logic ar, output logic acc);
    logic rel;
    logic [D*N-1:0] f;
    in_valid = v; in_coef = c; in_last = l; a_ready = ar;
    acc = v && (pend.size() < 2);
    rel = ar && (pend.size() > 0);
    @(posedge clk);
    if (rel) void'(pend.pop_front());
    exp_err = 1'b0;
    if (acc) begin
      cur.push_back(ref_reduce(c));
      if (l || cur.size() == D) begin
        if (l && cur.size() == D) begin
          f = '0;
          foreach (cur[k]) f[N*k +: N] = cur[k];
          pend.push_back(f);
        end else begin
          exp_err = 1'b1;
        end
        cur.delete();
      end
    end
    #1;
  endtask

  task automatic model_reset();
    cur.delete();
    pend.delete();
    exp_err = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; a_ready = 1'b0; in_coef = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (a_valid !== 1'b0) $display("FAIL reset_a_valid: got %b expected 0", a_valid); else n_pass++;
    n_checks++; if (a !== '0) $display("FAIL reset_a: got %h expected 0", a); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else n_pass++;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic acc;
    logic [D*N-1:0] exp_a;
    for (int i = 1; i <= D; i++) begin
      step(1'b1, N'(i), i == D, 1'b1, acc);
      n_checks++; if (frame_err !== 1'b0) $display("FAIL basic_err[%0d]: got %b expected 0", i, frame_err); else n_pass++;
      if (i < D) begin
        n_checks++; if (a_valid !== 1'b0) $display("FAIL basic_early_valid[%0d]: got %b expected 0", i, a_valid); else n_pass++;
      end
    end
    exp_a = '0;
    for (int k = 0; k < D; k++) exp_a[N*k +: N] = N'(k + 1);
    n_checks++; if (a_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", a_valid); else n_pass++;
    n_checks++; if (a !== exp_a) $display("FAIL basic_a: got %h expected %h", a, exp_a); else n_pass++;
    step(1'b0, '0, 1'b0, 1'b1, acc);
    n_checks++; if (a_valid !== 1'b0) $display("FAIL basic_release: got %b expected 0", a_valid); else n_pass++;
  endtask

  task automatic test_reduce();
    logic acc;
    int vals[8] = '{256, 257, 300, 511, 0, 1, 128, 256};
    int expv[8] = '{256, 0, 43, 254, 0, 1, 128, 256};
    for (int i = 0; i < D; i++) step(1'b1, N'(vals[i]), i == D - 1, 1'b0, acc);
    n_checks++; if (a_valid !== 1'b1) $display("FAIL reduce_valid: got %b expected 1", a_valid); else n_pass++;
    for (int k = 0; k < D; k++) begin
      n_checks++;
      if (a[N*k +: N] !== N'(expv[k])) $display("FAIL reduce_slot[%0d]: got %0d expected %0d", k, a[N*k +: N], expv[k]);
      else n_pass++;
    end
    step(1'b0, '0, 1'b0, 1'b1, acc);
    n_checks++; if (a_valid !== 1'b0) $display("FAIL reduce_release: got %b expected 0", a_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic acc;
    int pos = 0;
    int guard = 0;
    for (int i = 0; i < 24; i++) gen[i] = N'($urandom_range(0, 511));
    while (in_ready && guard < 40) begin
      step(1'b1, gen[pos], (pos % D) == D - 1, 1'b0, acc);
      if (acc) pos++;
      guard++;
    end
    n_checks++; if (pos != 2 * D) $display("FAIL bp_accepts: got %0d expected %0d", pos, 2 * D); else n_pass++;
    n_checks++; if (a !== frame_of(0)) $display("FAIL bp_frame1: got %h expected %h", a, frame_of(0)); else n_pass++;
    step(1'b1, gen[pos], 1'b0, 1'b0, acc);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_hold_ready: got %b expected 0", in_ready); else n_pass++;
    step(1'b1, gen[pos], 1'b0, 1'b1, acc);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (a_valid !== 1'b1) $display("FAIL bp_valid2: got %b expected 1", a_valid); else n_pass++;
    n_checks++; if (a !== frame_of(D)) $display("FAIL bp_frame2: got %h expected %h", a, frame_of(D)); else n_pass++;
    guard = 0;
    while (pos < 24 && guard < 40) begin
      step(1'b1, gen[pos], (pos % D) == D - 1, 1'b0, acc);
      if (acc) pos++;
      guard++;
    end
    n_checks++; if (pos != 24) $display("FAIL bp_fill3: got %0d expected 24", pos); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_again: got %b expected 0", in_ready); else n_pass++;
    step(1'b0, '0, 1'b0, 1'b1, acc);
    n_checks++; if (a !== frame_of(2 * D)) $display("FAIL bp_frame3: got %h expected %h", a, frame_of(2 * D)); else n_pass++;
    step(1'b0, '0, 1'b0, 1'b1, acc);
    n_checks++; if (a_valid !== 1'b0) $display("FAIL bp_drained: got %b expected 0", a_valid); else n_pass++;
  endtask

  task automatic test_early_last();
    logic acc;
    int errs = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, N'($urandom_range(0, 511)), i == 4, 1'b0, acc);
      if (frame_err === 1'b1) errs++;
    end
    n_checks++; if (frame_err !== 1'b1) $display("FAIL early_err_pulse: got %b expected 1", frame_err); else n_pass++;
    step(1'b0, '0, 1'b0, 1'b0, acc);
    if (frame_err === 1'b1) errs++;
    n_checks++; if (errs != 1) $display("FAIL early_err_count: got %0d expected 1", errs); else n_pass++;
    n_checks++; if (a_valid !== 1'b0) $display("FAIL early_valid: got %b expected 0", a_valid); else n_pass++;
    for (int i = 0; i < D; i++) gen[i] = N'($urandom_range(0, 511));
    for (int i = 0; i < D; i++) step(1'b1, gen[i], i == D - 1, 1'b0, acc);
    n_checks++; if (a_valid !== 1'b1) $display("FAIL early_next_valid: got %b expected 1", a_valid); else n_pass++;
    n_checks++; if (a !== frame_of(0)) $display("FAIL early_next_a: got %h expected %h", a, frame_of(0)); else n_pass++;
    step(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  task automatic test_missing_last();
    logic acc;
    int errs = 0;
    for (int i = 0; i < D; i++) begin
      step(1'b1, N'($urandom_range(0, 511)), 1'b0, 1'b0, acc);
      if (frame_err === 1'b1) errs++;
    end
    n_checks++; if (frame_err !== 1'b1) $display("FAIL missing_err_pulse: got %b expected 1", frame_err); else n_pass++;
    step(1'b0, '0, 1'b0, 1'b0, acc);
    if (frame_err === 1'b1) errs++;
    n_checks++; if (errs != 1) $display("FAIL missing_err_count: got %0d expected 1", errs); else n_pass++;
    n_checks++; if (a_valid !== 1'b0) $display("FAIL missing_valid: got %b expected 0", a_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL missing_ready: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic acc;
    for (int i = 0; i < 4; i++) step(1'b1, N'(i + 50), 1'b0, 1'b0, acc);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (a !== '0) $display("FAIL rstmid_a: got %h expected 0", a); else n_pass++;
    model_reset();
    release_reset();
    for (int i = 0; i < D; i++) step(1'b1, N'(i + 100), i == D - 1, 1'b0, acc);
    step(1'b1, N'(7), 1'b0, 1'b0, acc);
    step(1'b1, N'(9), 1'b1, 1'b0, acc);
    n_checks++; if (frame_err !== 1'b1) $display("FAIL rstfull_err_before: got %b expected 1", frame_err); else n_pass++;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstfull_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (a_valid !== 1'b0) $display("FAIL rstfull_valid: got %b expected 0", a_valid); else n_pass++;
    n_checks++; if (a !== '0) $display("FAIL rstfull_a: got %h expected 0", a); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL rstfull_err: got %b expected 0", frame_err); else n_pass++;
    model_reset();
    release_reset();
    for (int i = 0; i < D; i++) gen[i] = N'($urandom_range(0, 511));
    for (int i = 0; i < D; i++) step(1'b1, gen[i], i == D - 1, 1'b0, acc);
    n_checks++; if (a_valid !== 1'b1) $display("FAIL rstclean_valid: got %b expected 1", a_valid); else n_pass++;
    n_checks++; if (a !== frame_of(0)) $display("FAIL rstclean_a: got %h expected %h", a, frame_of(0)); else n_pass++;
    step(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  task automatic test_back_to_back();
    logic acc;
    int accepts = 0;
    int delivered = 0;
    for (int i = 0; i < 4 * D + 1; i++) begin
      if (a_valid === 1'b1) delivered++;
      step(i < 4 * D, N'($urandom_range(0, 511)), (i % D) == D - 1, 1'b1, acc);
      if (acc) accepts++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready); else n_pass++;
      n_checks++; if (a_valid !== (pend.size() > 0)) $display("FAIL b2b_valid[%0d]: got %b expected %b", i, a_valid, pend.size() > 0); else n_pass++;
      if (pend.size() > 0) begin
        n_checks++; if (a !== pend[0]) $display("FAIL b2b_a[%0d]: got %h expected %h", i, a, pend[0]); else n_pass++;
      end
    end
    n_checks++; if (accepts != 4 * D) $display("FAIL b2b_accepts: got %0d expected %0d", accepts, 4 * D); else n_pass++;
    n_checks++; if (delivered != 4) $display("FAIL b2b_frames: got %0d expected 4", delivered); else n_pass++;
  endtask

  task automatic test_random();
    logic acc;
    logic v, l, ar;
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom % 4) != 0;
      ar = ($urandom % 2) == 0;
      l  = (cur.size() == D - 1) ? (($urandom % 16) != 0) : (($urandom % 32) == 0);
      step(v, N'($urandom_range(0, 511)), l, ar, acc);
      n_checks++; if (in_ready !== (pend.size() < 2)) $display("FAIL rand_ready[%0d]: got %b expected %b", i, in_ready, pend.size() < 2); else n_pass++;
      n_checks++; if (a_valid !== (pend.size() > 0)) $display("FAIL rand_valid[%0d]: got %b expected %b", i, a_valid, pend.size() > 0); else n_pass++;
      n_checks++; if (frame_err !== exp_err) $display("FAIL rand_err[%0d]: got %b expected %b", i, frame_err, exp_err); else n_pass++;
      if (pend.size() > 0) begin
        n_checks++; if (a !== pend[0]) $display("FAIL rand_a[%0d]: got %h expected %h", i, a, pend[0]); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reduce();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
